// File: rtl/branch_unit.sv
// Branch resolver: RV funct3 compare, one-entry valid/ready result register, 2-bit BHT predictor.
// Optional resolved-branch / mispredict counters are built when BRANCH_STATS_EN is defined.
module branch_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic            pred_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispredict,
  output logic            illegal,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredict
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } f3_br_e;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;

  logic out_valid_q, out_valid_d;
  logic taken_q, taken_d;
  logic mispredict_q, mispredict_d;
  logic illegal_q, illegal_d;

  logic accept;
  logic res_taken;
  logic res_illegal;
  logic res_legal_branch;
  logic op_eq, op_lt, op_ltu;

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign upd_idx    = pc[IDX_W+1:2];
  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  assign pred_taken = bht_q[pred_idx][1];

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign op_eq  = (rs1 == rs2);
  assign op_lt  = ($signed(rs1) < $signed(rs2));
  assign op_ltu = (rs1 < rs2);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    res_taken        = 1'b0;
    res_illegal      = 1'b0;
    res_legal_branch = 1'b0;
    if (branch) begin
      res_legal_branch = 1'b1;
      case (f3_br_e'(funct3))
        F3_EQ:   res_taken = op_eq;
        F3_NE:   res_taken = !op_eq;
        F3_LT:   res_taken = op_lt;
        F3_GE:   res_taken = !op_lt;
        F3_LTU:  res_taken = op_ltu;
        F3_GEU:  res_taken = !op_ltu;
        default: begin
          res_illegal      = 1'b1;
          res_legal_branch = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (accept && res_legal_branch) begin
      if (res_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      taken_d      = res_taken;
      mispredict_d = res_taken ^ pred_in;
      illegal_d    = res_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the table is a flop array with a reset value rather than a RAM, because every counter must come up weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample their _d values from the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign illegal    = illegal_q;

`ifdef BRANCH_STATS_EN
  logic        is_branch_q, is_branch_d;
  logic        xfer;
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  // A flushed result is discarded, so it never counts as a transfer.
  assign xfer = out_valid_q && out_ready && !flush;

  always_comb begin
    is_branch_d       = is_branch_q;
    stat_branches_d   = stat_branches_q;
    stat_mispredict_d = stat_mispredict_q;
    if (accept) is_branch_d = branch;
    if (xfer && is_branch_q && !illegal_q) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (mispredict_q) stat_mispredict_d = stat_mispredict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_branch_q       <= 1'b0;
      stat_branches_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      is_branch_q       <= is_branch_d;
      stat_branches_q   <= stat_branches_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_branches   = stat_branches_q;
  assign stat_mispredict = stat_mispredict_q;
`else
  assign stat_branches   = '0;
  assign stat_mispredict = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0], pc[XLEN-1:IDX_W+2], pc[1:0]};

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_branch_unit;
  localparam int XLEN = 32;
  localparam int N    = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            in_valid;
  logic            in_ready;
  logic            branch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, pc;
  logic            pred_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            taken, mispredict, illegal;
  logic [31:0]     stat_branches, stat_mispredict;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .in_ready(in_ready), .branch(branch), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .pc(pc), .pred_in(pred_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .illegal(illegal),
    .stat_branches(stat_branches), .stat_mispredict(stat_mispredict)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counters as plain integers 0..3, one held result.
  int          bht [N];
  bit          m_valid, m_taken, m_mis, m_ill, m_br;
  int unsigned m_sb, m_sm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(N));
  endfunction

  function automatic bit model_pred(input logic [31:0] a);
    return bht[idx_of(a)] >= 2;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) bht[i] = 1;
    m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_br = 0;
    m_sb = 0; m_sm = 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"},  out_valid,  m_valid);
    check({tag, ".taken"},      taken,      m_taken);
    check({tag, ".mispredict"}, mispredict, m_mis);
    check({tag, ".illegal"},    illegal,    m_ill);
`ifdef BRANCH_STATS_EN
    check({tag, ".stat_br"},  stat_branches,   m_sb);
    check({tag, ".stat_mis"}, stat_mispredict, m_sm);
`else
    check({tag, ".stat_br"},  stat_branches,   32'd0);
    check({tag, ".stat_mis"}, stat_mispredict, 32'd0);
`endif
  endtask

  task automatic req(input bit v, input bit br, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] p, input bit pin);
    in_valid = v; branch = br; funct3 = f; rs1 = a; rs2 = b; pc = p; pred_in = pin;
  endtask

  // One clock: combinational checks at the negedge, model step, registered checks 1 time unit after posedge.
  task automatic cyc(input string tag);
    bit rdy, acc, ill, tk;
    int k;
    @(negedge clk);
    rdy = !flush && (!m_valid || out_ready);
    check({tag, ".pred_taken"}, pred_taken, model_pred(pred_pc));
    check({tag, ".in_ready"},   in_ready,   rdy);
    acc = in_valid && rdy;
    ill = branch && (funct3 == 3'd2 || funct3 == 3'd3);
    tk  = branch && !ill && ref_taken(funct3, rs1, rs2);
    if (m_valid && out_ready && !flush && m_br && !m_ill) begin
      m_sb++;
      if (m_mis) m_sm++;
    end
    if (acc && branch && !ill) begin
      k = idx_of(pc);
      if (tk) bht[k] = (bht[k] < 3) ? bht[k] + 1 : 3;
      else    bht[k] = (bht[k] > 0) ? bht[k] - 1 : 0;
    end
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_taken = tk; m_mis = tk ^ pred_in; m_ill = ill; m_br = branch;
    end else if (out_ready) m_valid = 0;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_tk [6];
    bit exp_pred [4];
    logic [2:0] f3s [6];
    int unsigned sb0, sm0;

    // Reset state
    rst = 1'b1;
    req(0, 0, 3'd0, 0, 0, 0, 0);
    flush = 0; out_ready = 1; pred_pc = 32'h100;
    model_reset();
    #12;
    check("reset.pred_taken", pred_taken, 1'b0);
    check_outputs("reset");
    rst = 1'b0;

    // Every funct3 on a negative-vs-positive operand pair
    f3s    = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_tk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      req(1, 1, f3s[i], 32'hfedcba98, 32'h12345678, 32'h80, 0);
      cyc("cmp");
      check($sformatf("cmp_f3_%0d", f3s[i]), taken, exp_tk[i]);
      check("cmp.valid_after_1", out_valid, 1'b1);
    end

    // Four taken BEQ at 0x40: counter 01->10->11->11
    exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
    pred_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 3'd0, 32'd5, 32'd5, 32'h40, model_pred(32'h40));
      check($sformatf("beq_pred_%0d", i), pred_taken, exp_pred[i]);
      cyc("beq");
      check($sformatf("beq_mis_%0d", i), mispredict, (i == 0));
    end

    // Alias: 0x140 shares the index of 0x40
    req(1, 1, 3'd1, 32'd1, 32'd2, 32'h40, 1);
    pred_pc = 32'h140;
    cyc("alias");
    check("alias.pred_taken", pred_taken, 1'b1);

    // Backpressure: result held for three cycles, second request waits
    req(1, 1, 3'd6, 32'd1, 32'd2, 32'h44, 0);
    cyc("bp.first");
    out_ready = 0;
    req(1, 1, 3'd5, 32'd1, 32'd2, 32'h48, 1);
    for (int i = 0; i < 3; i++) begin
      cyc("bp.hold");
      check("bp.in_ready_low", in_ready, 1'b0);
      check("bp.taken_stable", taken, 1'b1);
      check("bp.mis_stable", mispredict, 1'b1);
    end
    out_ready = 1;
    cyc("bp.release");
    check("bp.second_taken", taken, 1'b0);
    req(0, 0, 3'd0, 0, 0, 0, 0);
    cyc("bp.drain");

    // Flush with a held result and a pending request
    req(1, 1, 3'd0, 32'd3, 32'd3, 32'h4c, 0);
    cyc("fl.load");
    flush = 1; out_ready = 0;
    req(1, 1, 3'd0, 32'd3, 32'd3, 32'h4c, 0);
    cyc("fl.flush");
    check("fl.out_valid", out_valid, 1'b0);
    flush = 0; out_ready = 1;
    req(0, 0, 3'd0, 0, 0, 0, 0);
    cyc("fl.after");

    // Illegal funct3 leaves the counter alone
    pred_pc = 32'h50;
    req(1, 1, 3'd2, 32'd7, 32'd7, 32'h50, 1);
    cyc("ill.010");
    check("ill.flag", illegal, 1'b1);
    req(1, 1, 3'd3, 32'd7, 32'd7, 32'h50, 0);
    cyc("ill.011");
    req(0, 0, 3'd0, 0, 0, 0, 0);
    cyc("ill.bht");

    // Ten branches, three of them mispredicted
    sb0 = m_sb; sm0 = m_sm;
    for (int i = 0; i < 10; i++) begin
      req(1, 1, 3'd0, 32'd9, 32'd9, 32'h200 + 32'(4 * i), (i >= 3));
      cyc("stat");
    end
    req(0, 0, 3'd0, 0, 0, 0, 0);
    cyc("stat.drain");
`ifdef BRANCH_STATS_EN
    check("stat.branches10", stat_branches, sb0 + 10);
    check("stat.mispredict3", stat_mispredict, sm0 + 3);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      branch    = ($urandom_range(0, 4) != 0);
      funct3    = 3'($urandom_range(0, 7));
      pc        = $urandom & 32'h3fc;
      pred_pc   = ($urandom_range(0, 1) == 0) ? pc : ($urandom & 32'h3fc);
      pred_in   = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
    end
    flush = 0; out_ready = 1;

    // Mid-stream asynchronous reset
    pred_pc = 32'h40;
    req(1, 1, 3'd0, 32'd1, 32'd1, 32'h40, 0);
    cyc("mr.pre");
    req(1, 1, 3'd0, 32'd1, 32'd1, 32'h40, 0);
    cyc("mr.pre2");
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mr");
    check("mr.pred_taken", pred_taken, 1'b0);
    #1;
    rst = 1'b0;
    req(1, 1, 3'd0, 32'd1, 32'd1, 32'h40, 0);
    cyc("mr.post");
    req(0, 0, 3'd0, 0, 0, 0, 0);
    cyc("mr.post2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
